// File: rtl/data_mem_ctrl_pkg.sv
// rtl/data_mem_ctrl_pkg.sv - shared types and request classifier for the data memory stage
//
// Purpose: FSM state encoding, error code constants, counter width and the
//          request classification helper used by the controller.
// Ports:   none (package)

package data_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_RANGE    = 2'b10,
    ERR_CONFLICT = 2'b11
  } err_code_e;

  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int unsigned CNT_BITS = 4;

  // Priority: conflict > misaligned > out of range. Anything above the word
  // index field (bits ADDR_BITS+1:2) must be zero to be in range.
  function automatic err_code_e classify(input logic        rd,
                                         input logic        wr,
                                         input logic [31:0] addr,
                                         input int unsigned addr_bits);
    err_code_e code;
    code = ERR_NONE;
    if (rd && wr) begin
      code = ERR_CONFLICT;
    end else if (addr[1:0] != 2'b00) begin
      code = ERR_MISALIGN;
    end else if ((addr >> (addr_bits + 2)) != 32'd0) begin
      code = ERR_RANGE;
    end
    return code;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - processor-side request/response bundle of the data memory stage
//
// Purpose: groups the processor data-side handshake into one interface.
// Signals: mem_read, mem_write, data_addr[31:0], data_in[31:0]  (processor -> memory)
//          data_out[31:0], stall, done, err, err_code[1:0]       (memory -> processor)
// Modports: master = processor side, slave = memory controller side.

interface data_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        stall;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output mem_read, mem_write, data_addr, data_in,
    input  data_out, stall, done, err, err_code
  );

  modport slave (
    input  mem_read, mem_write, data_addr, data_in,
    output data_out, stall, done, err, err_code
  );
endinterface

// File: rtl/data_mem_ctrl_array.sv
// rtl/data_mem_ctrl_array.sv - DEPTH x 32 data RAM, synchronous write, asynchronous read
//
// Purpose: plain storage for the data memory stage; contents are never reset.
// Ports:   clk_i            rising-edge clock
//          we_i             write enable
//          waddr_i          word write index
//          wdata_i[31:0]    write data
//          raddr_i          word read index
//          rdata_o[31:0]    read data (combinational)

module data_mem_array #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data-side memory stage: checked, fixed-latency word access with stall/done
//
// Purpose: accepts processor read/write requests, rejects conflicting, misaligned
//          or out-of-range ones without touching memory, and otherwise performs a
//          word access to the data RAM after LATENCY cycles in BUSY.
// Ports:   clk        rising-edge clock
//          pc_reset   asynchronous active-high reset
//          bus        data_mem_if.slave (requests in; data_out/stall/done/err/err_code out)

module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned LATENCY   = 2
) (
  input  logic      clk,
  input  logic      pc_reset,
  data_mem_if.slave bus
);

  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] widx_q, widx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 is_write_q, is_write_d;
  logic [31:0]          data_out_q, data_out_d;
  logic                 err_q, err_d;
  err_code_e            err_code_q, err_code_d;

  logic                 req;
  err_code_e            req_err;
  logic                 ram_we;
  logic [31:0]          ram_rdata;
  logic                 stall_c;
  logic                 done_c;

  assign req     = bus.mem_read | bus.mem_write;
  assign req_err = classify(bus.mem_read, bus.mem_write, bus.data_addr, ADDR_BITS);

  data_mem_array #(
    .DEPTH     (DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (widx_q),
    .wdata_i (wdata_q),
    .raddr_i (widx_q),
    .rdata_o (ram_rdata)
  );

  // State register
  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = (req_err != ERR_NONE) ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic. Stall in IDLE is gated by reset so the processor sees all
  // outputs low while reset is held, even with request lines asserted.
  always_comb begin
    stall_c = 1'b0;
    done_c  = 1'b0;
    ram_we  = 1'b0;
    case (state_q)
      ST_IDLE: stall_c = req & ~pc_reset;
      ST_BUSY: begin
        stall_c = 1'b1;
        // Commit on the same edge that leaves BUSY, so a reset before then drops the write.
        ram_we  = (cnt_q == '0) & is_write_q;
      end
      ST_DONE: done_c = 1'b1;
      default: begin
        stall_c = 1'b0;
        done_c  = 1'b0;
      end
    endcase
  end

  // Datapath next-state: request latch, latency counter, read data and error flags
  always_comb begin
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    data_out_d = data_out_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          widx_d     = bus.data_addr[ADDR_BITS+1:2];
          wdata_d    = bus.data_in;
          is_write_d = bus.mem_write;
          if (req_err != ERR_NONE) begin
            err_d      = 1'b1;
            err_code_d = req_err;
          end else begin
            cnt_d = CNT_LOAD;
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (!is_write_q) begin
          data_out_d = ram_rdata;
        end
      end
      ST_DONE: begin
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
      end
      default: begin
        cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      cnt_q      <= '0;
      widx_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      data_out_q <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.stall    = stall_c;
  assign bus.done     = done_c;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed table-driven bench for data_mem_ctrl

module tb_data_mem_ctrl;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic pc_reset;
  always #5 clk = ~clk;

  data_mem_if bus();

  data_mem_ctrl #(
    .DEPTH     (256),
    .ADDR_BITS (8),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .pc_reset (pc_reset),
    .bus      (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [31:0] exp_data;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.data_addr = 32'h0;
    bus.data_in   = 32'h0;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_access(input vec_t v, input string tag);
    int n;
    bit seen;
    bus.mem_read  = v.rd;
    bus.mem_write = v.wr;
    bus.data_addr = v.addr;
    bus.data_in   = v.wdata;
    #1;
    check({tag, "/stall_req"}, 32'(bus.stall), 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (bus.done) seen = 1'b1;
    end
    check({tag, "/cycles"}, 32'(n), 32'(v.exp_cycles));
    check({tag, "/err"}, 32'(bus.err), 32'(v.exp_err));
    check({tag, "/err_code"}, 32'(bus.err_code), 32'(v.exp_code));
    check({tag, "/data_out"}, bus.data_out, v.exp_data);
    check({tag, "/stall_done"}, 32'(bus.stall), 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    check({tag, "/done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "/err_clear"}, 32'(bus.err), 32'd0);
  endtask

  initial begin
    int k;
    int n_done;
    int t_done[2];

    // rd, wr, addr, wdata, exp_err, exp_code, exp_data, exp_cycles
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0000_0000, LAT + 1});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 2'b00, 32'hDEAD_BEEF, LAT + 1});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 2'b01, 32'hDEAD_BEEF, 1});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 2'b10, 32'hDEAD_BEEF, 1});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0, 2'b00, 32'hDEAD_BEEF, LAT + 1});
    vecs.push_back('{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b1, 2'b11, 32'hDEAD_BEEF, 1});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 2'b00, 32'hCAFE_F00D, LAT + 1});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0BAD, 1'b1, 2'b01, 32'hCAFE_F00D, 1});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_0010, 32'h0,         1'b1, 2'b10, 32'hCAFE_F00D, 1});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_03FC, 32'h1111_2222, 1'b0, 2'b00, 32'hCAFE_F00D, LAT + 1});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 2'b00, 32'h1111_2222, LAT + 1});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 2'b00, 32'hDEAD_BEEF, LAT + 1});
    vecs.push_back('{1'b0, 1'b1, 32'h0000_0400, 32'h5555_5555, 1'b1, 2'b10, 32'hDEAD_BEEF, 1});

    // Reset state, with a request held so the stall gating is exercised.
    pc_reset = 1'b1;
    idle_inputs();
    bus.mem_read = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset/data_out", bus.data_out, 32'h0);
    check("reset/done", 32'(bus.done), 32'd0);
    check("reset/err", 32'(bus.err), 32'd0);
    check("reset/err_code", 32'(bus.err_code), 32'd0);
    check("reset/stall", 32'(bus.stall), 32'd0);
    idle_inputs();
    pc_reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_access(vecs[i], $sformatf("vec%0d", i));
    end

    // Write 0x5 to 0x3FC, reset mid-cycle while BUSY: write must be dropped.
    bus.mem_write = 1'b1;
    bus.data_addr = 32'h0000_03FC;
    bus.data_in   = 32'h0000_0005;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort/stall_busy", 32'(bus.stall), 32'd1);
    #3;
    pc_reset = 1'b1;
    idle_inputs();
    #1;
    check("abort/data_out", bus.data_out, 32'h0);
    check("abort/stall", 32'(bus.stall), 32'd0);
    check("abort/done", 32'(bus.done), 32'd0);
    check("abort/err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    pc_reset = 1'b0;
    @(posedge clk); #1;
    run_access('{1'b1, 1'b0, 32'h0000_03FC, 32'h0, 1'b0, 2'b00, 32'h1111_2222, LAT + 1}, "abort_read");

    // Back-to-back: hold mem_read through done; pulses LAT+2 cycles apart.
    bus.mem_read  = 1'b1;
    bus.data_addr = 32'h0000_0010;
    n_done = 0;
    t_done[0] = 0;
    t_done[1] = 0;
    k = 0;
    while (n_done < 2 && k < 30) begin
      @(posedge clk); #1;
      k++;
      if (bus.done) begin
        t_done[n_done] = k;
        n_done++;
        check($sformatf("b2b/stall_done%0d", n_done), 32'(bus.stall), 32'd0);
        check($sformatf("b2b/data%0d", n_done), bus.data_out, 32'hDEAD_BEEF);
      end
    end
    idle_inputs();
    check("b2b/num_done", 32'(n_done), 32'd2);
    check("b2b/first_done", 32'(t_done[0]), 32'(LAT + 1));
    check("b2b/spacing", 32'(t_done[1] - t_done[0]), 32'(LAT + 2));
    @(posedge clk); #1;
    check("b2b/idle_stall", 32'(bus.stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
